// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core: load-use interlock, data-memory
// freeze and branch flush, merged into one prioritised set of pipeline-register enables.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W  = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsrc1_ifid,
  input  logic                  rsrc1_used,
  input  logic [REG_ADDR_W-1:0] rsrc2_ifid,
  input  logic                  rsrc2_used,
  input  logic [REG_ADDR_W-1:0] rdst_idex,
  input  logic                  memread_idex,
  input  logic                  mem_busy,
  input  logic                  flush_ex,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  mem_timeout
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              hazard;
  logic [WAIT_W-1:0] wait_cnt;

  assign hazard = memread_idex &
                  ((rsrc1_used & (rsrc1_ifid == rdst_idex)) |
                   (rsrc2_used & (rsrc2_ifid == rdst_idex)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Priority: reset > mem_busy > flush_ex > hazard; MEM_WAIT without busy behaves as RUN.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    state_next  = RUN;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_next  = MEM_WAIT;
    end else if (flush_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard && (state != BUBBLE)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_next  = BUBBLE;
    end
  end

  // Counts consecutive busy cycles, the freeze-entry cycle included, so the flag
  // rises at the edge closing the MEM_TIMEOUT-th busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (mem_busy) begin
      if (wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (mem_busy && (wait_cnt == WAIT_LAST)) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl: load-use, flush, memory freeze,
// timeout and reset behaviour with hand-computed expectations.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  rsrc1_ifid;
  logic        rsrc1_used;
  logic [2:0]  rsrc2_ifid;
  logic        rsrc2_used;
  logic [2:0]  rdst_idex;
  logic        memread_idex;
  logic        mem_busy;
  logic        flush_ex;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_bubble;
  logic        exmem_write;
  logic [15:0] stall_cycles;
  logic        mem_timeout;
  logic [5:0]  ctrl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;

  // ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] CTRL_NORMAL = 6'b110101;
  localparam logic [5:0] CTRL_STALL  = 6'b000111;
  localparam logic [5:0] CTRL_FLUSH  = 6'b111111;
  localparam logic [5:0] CTRL_FREEZE = 6'b000000;

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write};

  hazard_stall_ctrl #(.REG_ADDR_W(3), .CNT_W(16), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rsrc1_ifid(rsrc1_ifid), .rsrc1_used(rsrc1_used),
    .rsrc2_ifid(rsrc2_ifid), .rsrc2_used(rsrc2_used),
    .rdst_idex(rdst_idex), .memread_idex(memread_idex),
    .mem_busy(mem_busy), .flush_ex(flush_ex),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    rsrc1_ifid = 3'd1; rsrc1_used = 1'b1;
    rsrc2_ifid = 3'd3; rsrc2_used = 1'b1;
    rdst_idex  = 3'd5; memread_idex = 1'b0;
    mem_busy   = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic set_hazard();
    set_idle();
    rdst_idex = 3'd2; memread_idex = 1'b1; rsrc1_ifid = 3'd2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_FREEZE) begin
      n_fail++; $display("[TB] FAIL reset_ctrl got=%b exp=%b", ctrl, CTRL_FREEZE);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_stall_cycles got=%0d exp=0", stall_cycles);
    end
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mem_timeout got=%b exp=0", mem_timeout);
    end
    rst = 1'b0;
    next_cycle();
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    set_hazard();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL load_use_stall got=%b exp=%b", ctrl, CTRL_STALL);
    end
    exp_stall++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL load_use_advance got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL load_use_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_no_hazard();
    set_hazard(); memread_idex = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL no_hazard_not_load got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    set_hazard(); rsrc1_used = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL no_hazard_unused got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    set_hazard(); rsrc1_ifid = 3'd0; rsrc2_ifid = 3'd0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL no_hazard_src0 got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    set_idle(); rdst_idex = 3'd0; memread_idex = 1'b1; rsrc1_used = 1'b0; rsrc2_ifid = 3'd0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL hazard_src2_r0 got=%b exp=%b", ctrl, CTRL_STALL);
    end
    exp_stall++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL no_hazard_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_hazard_held();
    set_hazard();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL held_first got=%b exp=%b", ctrl, CTRL_STALL);
    end
    exp_stall++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL held_bubble_suppress got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL held_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    set_hazard(); flush_ex = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_FLUSH) begin
      n_fail++; $display("[TB] FAIL flush_over_hazard got=%b exp=%b", ctrl, CTRL_FLUSH);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL flush_after got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL flush_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_mem_busy();
    int bad;
    bad = 0;
    set_hazard(); flush_ex = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ctrl !== CTRL_FREEZE) bad++;
      exp_stall++;
      next_cycle();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL busy_freeze bad_cycles=%0d exp=0", bad);
    end
    set_hazard();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL wait_exit_as_run got=%b exp=%b", ctrl, CTRL_STALL);
    end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL busy_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL busy_short_timeout got=%b exp=0", mem_timeout);
    end
    exp_stall++;
    next_cycle();
    set_idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_hazard();
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL b2b_stall got=%b exp=%b", ctrl, CTRL_STALL);
    end
    exp_stall++;
    next_cycle();
    mem_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_FREEZE) begin
      n_fail++; $display("[TB] FAIL b2b_busy_in_bubble got=%b exp=%b", ctrl, CTRL_FREEZE);
    end
    exp_stall++;
    next_cycle();
    set_hazard(); memread_idex = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL b2b_after_wait got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_mem_timeout();
    set_idle(); mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_stall++;
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_15_cycles got=%b exp=0", mem_timeout);
    end
    next_cycle();
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_stall++;
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL timeout_early got=%b exp=0", mem_timeout);
    end
    exp_stall++;
    next_cycle();
    mem_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_set got=%b exp=1", mem_timeout);
    end
    n_checks++;
    if (ctrl !== CTRL_NORMAL) begin
      n_fail++; $display("[TB] FAIL timeout_release got=%b exp=%b", ctrl, CTRL_NORMAL);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("[TB] FAIL timeout_sticky got=%b exp=1", mem_timeout);
    end
    n_checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      n_fail++; $display("[TB] FAIL timeout_count got=%0d exp=%0d", stall_cycles, exp_stall);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    set_idle(); mem_busy = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== CTRL_FREEZE) begin
      n_fail++; $display("[TB] FAIL rst_wait_ctrl got=%b exp=%b", ctrl, CTRL_FREEZE);
    end
    next_cycle();
    rst = 1'b0;
    set_hazard();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'd0) begin
      n_fail++; $display("[TB] FAIL rst_wait_count got=%0d exp=0", stall_cycles);
    end
    n_checks++;
    if (mem_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_wait_timeout got=%b exp=0", mem_timeout);
    end
    n_checks++;
    if (ctrl !== CTRL_STALL) begin
      n_fail++; $display("[TB] FAIL rst_then_run got=%b exp=%b", ctrl, CTRL_STALL);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 16'd1) begin
      n_fail++; $display("[TB] FAIL rst_then_count got=%0d exp=1", stall_cycles);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    next_cycle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_hazard_held();
    test_flush();
    test_mem_busy();
    test_back_to_back();
    test_mem_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
